// File: rtl/rca_chunked_addsub.sv
// Multi-cycle ripple-carry adder/subtractor: CHUNK bits per clock, LSB chunk first,
// inter-chunk carry kept in a register, valid/ready handshake on both sides.
module rca_chunked_addsub #(
    parameter  int WIDTH      = 36,
    parameter  int CHUNK      = 9,
    localparam int NUM_CHUNKS = WIDTH / CHUNK
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_carry,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_overflow
);

    localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
            $error("rca_chunked_addsub: WIDTH must be an integer multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               carry_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   sum_reg;

    logic [CHUNK-1:0]   chunk_a;
    logic [CHUNK-1:0]   chunk_b;
    logic [CHUNK-1:0]   chunk_sum;
    logic               chunk_cout;
    logic               carry_msb;
    logic               c;
    int                 chunk_base;
    logic [WIDTH-1:0]   sum_next;

    // Handshake flags are pure decodes of the registered state.
    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    // One CHUNK-bit ripple chain, reused for every chunk of the operand.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned
        // (which would infer a latch); blocking '=' is right for combinational logic.
        chunk_base = int'(cnt) * CHUNK;
        chunk_a    = a_reg[chunk_base +: CHUNK];
        chunk_b    = b_reg[chunk_base +: CHUNK];
        chunk_sum  = '0;
        carry_msb  = 1'b0;
        c          = carry_reg;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                carry_msb = c;
            end
            chunk_sum[i] = chunk_a[i] ^ chunk_b[i] ^ c;
            c = (chunk_a[i] & chunk_b[i]) | (c & (chunk_a[i] ^ chunk_b[i]));
        end
        chunk_cout = c;
        sum_next   = sum_reg;
        sum_next[chunk_base +: CHUNK] = chunk_sum;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the operand and partial-sum registers are left out of reset on
            // purpose: each is fully rewritten before it is ever read.
            state      <= IDLE;
            cnt        <= '0;
            carry_reg  <= 1'b0;
            o_result   <= '0;
            o_overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking '<=' for all state so every register samples
            // pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        a_reg     <= i_add_term1;
                        b_reg     <= i_sub ? ~i_add_term2 : i_add_term2;
                        // Subtract is A + ~B + ~borrow_in.
                        carry_reg <= i_carry ^ i_sub;
                        cnt       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= chunk_cout;
                    if (cnt == LAST_CHUNK) begin
                        o_result   <= {chunk_cout, sum_next};
                        o_overflow <= carry_msb ^ chunk_cout;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_chunked_addsub.sv
// Directed, table-driven bench for rca_chunked_addsub: default (36/9) instance plus
// a single-chunk (36/36) instance sharing the operand bus.
module tb_rca_chunked_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic [35:0] op_a, op_b;
    logic        op_cin, op_sub;

    logic        m_valid, m_ready, m_o_ready, m_o_valid, m_o_ovf;
    logic [36:0] m_o_result;
    logic        v_valid, v_ready, v_o_ready, v_o_valid, v_o_ovf;
    logic [36:0] v_o_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rca_chunked_addsub dut (
        .i_clk(clk), .i_rst(rst), .i_valid(m_valid), .o_ready(m_o_ready),
        .i_add_term1(op_a), .i_add_term2(op_b), .i_carry(op_cin), .i_sub(op_sub),
        .o_valid(m_o_valid), .i_ready(m_ready), .o_result(m_o_result), .o_overflow(m_o_ovf)
    );

    rca_chunked_addsub #(.WIDTH(36), .CHUNK(36)) dut_single (
        .i_clk(clk), .i_rst(rst), .i_valid(v_valid), .o_ready(v_o_ready),
        .i_add_term1(op_a), .i_add_term2(op_b), .i_carry(op_cin), .i_sub(op_sub),
        .o_valid(v_o_valid), .i_ready(v_ready), .o_result(v_o_result), .o_overflow(v_o_ovf)
    );

    typedef struct {
        string       name;
        logic [35:0] a;
        logic [35:0] b;
        logic        cin;
        logic        sub;
        logic [36:0] res;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation to the selected instance and return result, overflow and
    // accept-to-valid latency (-1 if the result never arrived).
    task automatic run_op(input bit sel, input logic [35:0] a, input logic [35:0] b,
                          input logic cin, input logic sub,
                          output logic [36:0] res, output logic ovf, output int lat);
        bit got;
        @(negedge clk);
        op_a = a; op_b = b; op_cin = cin; op_sub = sub;
        if (sel) v_valid = 1'b1; else m_valid = 1'b1;
        check("ready_before_accept", sel ? v_o_ready : m_o_ready, 1);
        @(negedge clk);
        m_valid = 1'b0; v_valid = 1'b0;
        op_a = {$urandom, $urandom};
        op_b = {$urandom, $urandom};
        op_cin = 1'($urandom); op_sub = 1'($urandom);
        lat = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (sel ? v_o_valid : m_o_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("result_timeout", 0, 1);
            lat = -1;
        end
        res = sel ? v_o_result : m_o_result;
        ovf = sel ? v_o_ovf : m_o_ovf;
        if (sel) v_ready = 1'b1; else m_ready = 1'b1;
        @(negedge clk);
        check("valid_drops_after_handshake", sel ? v_o_valid : m_o_valid, 0);
        m_ready = 1'b0; v_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [36:0] res;
        logic        ovf;
        int          lat;
        int          gap;
        bit          seen;

        vecs[0] = '{"carry_out",      36'hF_FFFF_FFFF, 36'h1,           1'b0, 1'b0, 37'h10_0000_0000, 1'b0};
        vecs[1] = '{"sub_borrow",     36'h5,           36'h7,           1'b0, 1'b1, 37'h0F_FFFF_FFFE, 1'b0};
        vecs[2] = '{"sub_borrow_cin", 36'h5,           36'h7,           1'b1, 1'b1, 37'h0F_FFFF_FFFD, 1'b0};
        vecs[3] = '{"add_ovf",        36'h7_FFFF_FFFF, 36'h1,           1'b0, 1'b0, 37'h08_0000_0000, 1'b1};
        vecs[4] = '{"sub_ovf",        36'h8_0000_0000, 36'h1,           1'b0, 1'b1, 37'h17_FFFF_FFFF, 1'b1};
        vecs[5] = '{"add_cin",        36'h3,           36'h4,           1'b1, 1'b0, 37'h8,            1'b0};
        vecs[6] = '{"chunk_carry",    36'h1FF,         36'h1,           1'b0, 1'b0, 37'h200,          1'b0};
        vecs[7] = '{"sub_zero",       36'h0,           36'h0,           1'b0, 1'b1, 37'h10_0000_0000, 1'b0};
        vecs[8] = '{"neg_neg_ovf",    36'h8_0000_0000, 36'h8_0000_0000, 1'b0, 1'b0, 37'h10_0000_0000, 1'b1};
        vecs[9] = '{"mixed_sign",     36'h1_2345_6789, 36'h8_7654_3210, 1'b0, 1'b0, 37'h09_9999_9999, 1'b0};

        rst = 1'b1; m_valid = 1'b1; v_valid = 1'b1; m_ready = 1'b0; v_ready = 1'b0;
        op_a = '0; op_b = '0; op_cin = 1'b0; op_sub = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", m_o_valid, 0);
        check("reset_result", m_o_result, 0);
        check("reset_ovf", m_o_ovf, 0);
        m_valid = 1'b0; v_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", m_o_ready, 1);
        check("single_ready_after_reset", v_o_ready, 1);

        for (int i = 0; i < 10; i++) begin
            run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, res, ovf, lat);
            check({vecs[i].name, "_result"}, res, vecs[i].res);
            check({vecs[i].name, "_ovf"}, ovf, vecs[i].ovf);
            check({vecs[i].name, "_latency"}, lat, 4);
        end

        // Backpressure: result held, new operands refused while the consumer stalls.
        @(negedge clk);
        op_a = 36'h10; op_b = 36'h20; op_cin = 1'b0; op_sub = 1'b0; m_valid = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = m_o_valid;
        end
        check("bp_valid_arrives", seen, 1);
        check("bp_result", m_o_result, 37'h30);
        for (int i = 0; i < 10; i++) begin
            m_valid = (i % 2 == 0);
            op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
            @(negedge clk);
            check("bp_valid_held", m_o_valid, 1);
            check("bp_result_held", m_o_result, 37'h30);
            check("bp_ready_low", m_o_ready, 0);
        end
        m_valid = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", m_o_valid, 0);
        check("bp_ready_back", m_o_ready, 1);
        check("bp_result_kept", m_o_result, 37'h30);
        m_ready = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (m_o_valid || !m_o_ready) seen = 1'b1;
        end
        check("bp_no_stray_accept", seen, 0);

        // Back-to-back: valid pulses spaced NUM_CHUNKS+2 cycles with both sides always ready.
        op_a = 36'h1; op_b = 36'h1; op_cin = 1'b0; op_sub = 1'b0;
        m_valid = 1'b1; m_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = m_o_valid;
        end
        check("tp_first_valid", seen, 1);
        gap = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (m_o_valid) begin
                gap = i;
                break;
            end
        end
        m_valid = 1'b0;
        check("tp_spacing", gap, 6);
        check("tp_result", m_o_result, 37'h2);
        @(negedge clk);
        m_ready = 1'b0;

        // Reset mid-operation aborts silently.
        @(negedge clk);
        op_a = 36'h1_2345_6789; op_b = 36'h1; op_cin = 1'b0; op_sub = 1'b0; m_valid = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; m_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; m_valid = 1'b0;
        check("abort_ready", m_o_ready, 1);
        check("abort_result", m_o_result, 0);
        check("abort_ovf", m_o_ovf, 0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (m_o_valid) seen = 1'b1;
        end
        check("abort_no_valid", seen, 0);
        run_op(1'b0, 36'h3, 36'h4, 1'b0, 1'b0, res, ovf, lat);
        check("after_abort_result", res, 37'h7);
        check("after_abort_latency", lat, 4);

        // Single-chunk instance: whole width in one cycle.
        run_op(1'b1, 36'hA_AAAA_AAAA, 36'h5_5555_5555, 1'b1, 1'b0, res, ovf, lat);
        check("single_result", res, 37'h10_0000_0000);
        check("single_ovf", ovf, 0);
        check("single_latency", lat, 1);
        run_op(1'b1, 36'h8_0000_0000, 36'h1, 1'b0, 1'b1, res, ovf, lat);
        check("single_sub_result", res, 37'h17_FFFF_FFFF);
        check("single_sub_ovf", ovf, 1);
        check("single_sub_latency", lat, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
